// File: rtl/fifo_wr_arb_ctrl_pkg.sv
// Shared pointer helpers and defaults for the async FIFO.
// Gray/binary conversions work on any pointer width up to CW bits.
package fifo_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int CW = 32;

  typedef logic [DEF_ADDR_W:0] ptr_t;

  function automatic logic [CW-1:0] bin2gray(
    input logic [CW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CW-1:0] gray2bin(
    input logic [CW-1:0] g
  );
    logic [CW-1:0] b;
    b[CW-1] = g[CW-1];
    for (int i = CW - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant,
// registered index of the last granted requester.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] gidx
);

  logic [IDXW-1:0] rr_last;
  logic            found;
  int              j;

  // Search circularly starting just after the last winner.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(rr_last) + k;
      if (j >= NREQ)
        j = j - NREQ;
      if (!found && en && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        gidx     = IDXW'(j);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rr_last <= IDXW'(NREQ - 1);
    else if (found)
      rr_last <= gidx;
  end

endmodule

// File: rtl/fifo_wr_arb_ctrl_sync.sv
// Two-flop synchronizer for multi-bit gray-coded values.
// Async active-high reset clears both stages.
module sync #(
  parameter int SIZE = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  logic [SIZE-1:0] s1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// Async FIFO write-side controller: round-robin requester
// arbitration, memory write port, write pointers, full/free count.
module fifo_wr_arb_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREQ   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        grant,
  input  logic [ADDR_W:0]        rptr_gray_async,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_waddr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [ADDR_W:0]        wptr_gray,
  output logic                   full,
  output logic [ADDR_W:0]        free_cnt
);

  localparam int PW   = ADDR_W + 1;
  localparam int IDXW = $clog2(NREQ);
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [PW-1:0]     wbin;
  logic [PW-1:0]     wnext;
  logic [PW-1:0]     rq2;
  logic [PW-1:0]     rbin_s;
  logic [PW-1:0]     full_cmp;
  logic [CW-1:0]     wbin_g;
  logic [CW-1:0]     wnext_g;
  logic [CW-1:0]     rq2_b;
  logic [IDXW-1:0]   gidx;
  logic [DATA_W-1:0] sel_data;
  logic              accept;
  logic              arb_en;
  logic              unused_hi;

  sync #(
    .SIZE(PW)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rptr_gray_async),
    .q    (rq2)
  );

  // No grants while full or while reset is held.
  assign arb_en = ~full & ~reset;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clock(clock),
    .reset(reset),
    .en   (arb_en),
    .req  (req),
    .grant(grant),
    .gidx (gidx)
  );

  assign accept   = |grant;
  assign sel_data = wdata[gidx*DATA_W +: DATA_W];
  assign wnext    = wbin + PW'(accept);

  assign wbin_g  = bin2gray(CW'(wbin));
  assign wnext_g = bin2gray(CW'(wnext));
  assign rq2_b   = gray2bin(CW'(rq2));
  assign rbin_s  = rq2_b[PW-1:0];

  // Full when write pointer is exactly one lap ahead of read.
  assign full_cmp = {~rq2[ADDR_W -: 2], rq2[ADDR_W-2:0]};

  assign unused_hi = ^{wbin_g[CW-1:PW], wnext_g[CW-1:PW],
                       rq2_b[CW-1:PW]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wbin      <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      wptr_gray <= '0;
      full      <= 1'b0;
      free_cnt  <= DEPTH;
    end else begin
      if (accept) begin
        mem_we    <= 1'b1;
        mem_waddr <= wbin[ADDR_W-1:0];
        mem_wdata <= sel_data;
        wbin      <= wnext;
      end else begin
        mem_we    <= 1'b0;
      end
      // Published one cycle behind wbin so memory is written first.
      wptr_gray <= wbin_g[PW-1:0];
      full      <= (wnext_g[PW-1:0] == full_cmp);
      free_cnt  <= DEPTH - (wnext - rbin_s);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Directed self-checking bench for fifo_wr_arb_ctrl
// (NREQ=2 instance plus an NREQ=3 instance for arbitration order).
module tb_fifo_wr_arb_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [15:0] wdata;
  logic [1:0] grant;
  logic [4:0] rptr;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [4:0] wptr_gray;
  logic       full;
  logic [4:0] free_cnt;

  logic [2:0]  req3;
  logic [23:0] wdata3;
  logic [2:0]  grant3;
  logic [4:0]  rptr3;
  logic        mem_we3;
  logic [3:0]  mem_waddr3;
  logic [7:0]  mem_wdata3;
  logic [4:0]  wptr_gray3;
  logic        full3;
  logic [4:0]  free_cnt3;

  int vec = 0;
  int err = 0;

  always #5 clock = ~clock;

  fifo_wr_arb_ctrl #(.ADDR_W(4), .DATA_W(8), .NREQ(2)) dut (
    .clock(clock), .reset(reset), .req(req), .wdata(wdata),
    .grant(grant), .rptr_gray_async(rptr), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wptr_gray(wptr_gray), .full(full), .free_cnt(free_cnt)
  );

  fifo_wr_arb_ctrl #(.ADDR_W(4), .DATA_W(8), .NREQ(3)) dut3 (
    .clock(clock), .reset(reset), .req(req3), .wdata(wdata3),
    .grant(grant3), .rptr_gray_async(rptr3), .mem_we(mem_we3),
    .mem_waddr(mem_waddr3), .mem_wdata(mem_wdata3),
    .wptr_gray(wptr_gray3), .full(full3), .free_cnt(free_cnt3)
  );

  function automatic logic [4:0] g5(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    req3  = 3'b000;
    rptr  = 'x;
    @(negedge clock);
    @(negedge clock);
    rptr  = 5'd0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] exp;
    reset = 1'b1;
    req   = 2'b11;
    rptr  = 'x;
    @(negedge clock);
    @(negedge clock);
    vec++; if (grant !== 2'b00) begin err++;
      $display("FAIL rst_grant got=%b exp=00", grant); end
    vec++; if (free_cnt !== 5'd16) begin err++;
      $display("FAIL rst_free got=%0d exp=16", free_cnt); end
    vec++; if (full !== 1'b0) begin err++;
      $display("FAIL rst_full got=%b exp=0", full); end
    vec++; if (mem_we !== 1'b0) begin err++;
      $display("FAIL rst_we got=%b exp=0", mem_we); end
    vec++; if (wptr_gray !== 5'd0) begin err++;
      $display("FAIL rst_wptr got=%b exp=0", wptr_gray); end
    rptr  = 5'd0;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      vec++; if (grant !== exp) begin err++;
        $display("FAIL alt_grant k=%0d got=%b exp=%b", k, grant, exp); end
      @(negedge clock);
    end
    req = 2'b00;
  endtask

  task automatic test_fill();
    do_reset();
    req = 2'b10;
    for (int i = 0; i < 16; i++) begin
      wdata = {8'(8'h40 + i), 8'h00};
      #1;
      vec++; if (grant !== 2'b10) begin err++;
        $display("FAIL fill_grant i=%0d got=%b exp=10", i, grant); end
      @(negedge clock);
      vec++; if (mem_we !== 1'b1 || mem_waddr !== 4'(i)) begin err++;
        $display("FAIL fill_wr i=%0d we=%b addr=%0d exp_addr=%0d",
                 i, mem_we, mem_waddr, i); end
      vec++; if (mem_wdata !== 8'(8'h40 + i)) begin err++;
        $display("FAIL fill_data i=%0d got=%h exp=%h",
                 i, mem_wdata, 8'(8'h40 + i)); end
      vec++; if (free_cnt !== 5'(15 - i)) begin err++;
        $display("FAIL fill_free i=%0d got=%0d exp=%0d",
                 i, free_cnt, 15 - i); end
    end
    vec++; if (full !== 1'b1) begin err++;
      $display("FAIL fill_full got=%b exp=1", full); end
    vec++; if (grant !== 2'b00) begin err++;
      $display("FAIL full_nogrant got=%b exp=00", grant); end
    @(negedge clock);
    vec++; if (mem_we !== 1'b0) begin err++;
      $display("FAIL full_we got=%b exp=0", mem_we); end
    vec++; if (wptr_gray !== 5'b11000) begin err++;
      $display("FAIL fill_wptr got=%b exp=11000", wptr_gray); end
    vec++; if (req !== 2'b10 || grant !== 2'b00) begin err++;
      $display("FAIL full_hold req=%b grant=%b exp 10/00", req, grant); end
  endtask

  task automatic test_read_free();
    rptr  = 5'b00001;
    wdata = {8'h99, 8'h00};
    for (int e = 1; e <= 2; e++) begin
      @(negedge clock);
      vec++; if (full !== 1'b1 || grant !== 2'b00) begin err++;
        $display("FAIL rd_lat e=%0d full=%b grant=%b exp 1/00",
                 e, full, grant); end
    end
    @(negedge clock);
    vec++; if (full !== 1'b0 || free_cnt !== 5'd1) begin err++;
      $display("FAIL rd_free full=%b free=%0d exp 0/1", full, free_cnt); end
    vec++; if (grant !== 2'b10) begin err++;
      $display("FAIL rd_grant got=%b exp=10", grant); end
    @(negedge clock);
    vec++; if (mem_we !== 1'b1 || mem_waddr !== 4'd0) begin err++;
      $display("FAIL rd_wr we=%b addr=%0d exp 1/0", mem_we, mem_waddr); end
    vec++; if (mem_wdata !== 8'h99) begin err++;
      $display("FAIL rd_data got=%h exp=99", mem_wdata); end
    vec++; if (full !== 1'b1 || free_cnt !== 5'd0) begin err++;
      $display("FAIL rd_refull full=%b free=%0d exp 1/0", full, free_cnt); end
    req = 2'b00;
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    logic [3:0] paddr;
    int wraps;
    wraps = 0;
    prev  = 5'd0;
    paddr = 4'd0;
    do_reset();
    req = 2'b10;
    for (int i = 0; i < 40; i++) begin
      rptr = g5(i >= 3 ? i - 3 : 0);
      #1;
      vec++; if (grant !== 2'b10) begin err++;
        $display("FAIL wrap_grant i=%0d got=%b exp=10", i, grant); end
      @(negedge clock);
      vec++; if (mem_waddr !== 4'(i % 16) || mem_we !== 1'b1) begin err++;
        $display("FAIL wrap_addr i=%0d got=%0d exp=%0d",
                 i, mem_waddr, i % 16); end
      vec++; if (full !== 1'b0) begin err++;
        $display("FAIL wrap_full i=%0d got=%b exp=0", i, full); end
      vec++; if (wptr_gray !== g5(i)) begin err++;
        $display("FAIL wrap_wptr i=%0d got=%b exp=%b", i, wptr_gray, g5(i)); end
      if (i > 0) begin
        vec++; if ($countones(prev ^ wptr_gray) != 1) begin err++;
          $display("FAIL wrap_gray1 i=%0d prev=%b cur=%b", i, prev, wptr_gray); end
        if (paddr == 4'd15 && mem_waddr == 4'd0)
          wraps++;
      end
      prev  = wptr_gray;
      paddr = mem_waddr;
    end
    vec++; if (wraps != 2) begin err++;
      $display("FAIL wrap_count got=%0d exp=2", wraps); end
    req = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b10;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    #1;
    vec++; if (mem_we !== 1'b0 || wptr_gray !== 5'd0) begin err++;
      $display("FAIL mid_rst we=%b wptr=%b exp 0/0", mem_we, wptr_gray); end
    vec++; if (free_cnt !== 5'd16 || full !== 1'b0) begin err++;
      $display("FAIL mid_rst_free free=%0d full=%b exp 16/0", free_cnt, full); end
    vec++; if (grant !== 2'b00) begin err++;
      $display("FAIL mid_rst_grant got=%b exp=00", grant); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    vec++; if (grant !== 2'b10) begin err++;
      $display("FAIL mid_rel_grant got=%b exp=10", grant); end
    @(negedge clock);
    vec++; if (mem_we !== 1'b1 || mem_waddr !== 4'd0) begin err++;
      $display("FAIL mid_rel_wr we=%b addr=%0d exp 1/0", mem_we, mem_waddr); end
    req = 2'b00;
  endtask

  task automatic test_three();
    int seq [7];
    logic [7:0] dat [3];
    seq = '{0, 1, 2, 0, 2, 0, 2};
    dat = '{8'h11, 8'h22, 8'h33};
    do_reset();
    rptr3  = 5'd0;
    wdata3 = {8'h33, 8'h22, 8'h11};
    req3   = 3'b111;
    for (int k = 0; k < 7; k++) begin
      if (k == 3)
        req3 = 3'b101;
      #1;
      vec++; if (grant3 !== 3'(1 << seq[k])) begin err++;
        $display("FAIL rr3_grant k=%0d got=%b exp=%b",
                 k, grant3, 3'(1 << seq[k])); end
      @(negedge clock);
      vec++; if (mem_wdata3 !== dat[seq[k]]) begin err++;
        $display("FAIL rr3_data k=%0d got=%h exp=%h",
                 k, mem_wdata3, dat[seq[k]]); end
    end
    req3 = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    req    = 2'b00;
    wdata  = 16'h0000;
    rptr   = 5'd0;
    req3   = 3'b000;
    wdata3 = 24'h0;
    rptr3  = 5'd0;
    test_reset();
    test_fill();
    test_read_free();
    test_wrap();
    test_reset_mid();
    test_three();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb_ctrl.md
Name: fifo_wr_arb_ctrl

Overview:
- Write-side controller for the async FIFO.
- Arbitrates round-robin among NREQ write requesters and drives the dual-port memory write port.
- Maintains the binary and gray write pointers and generates full and free-count.
- Brings the read-domain gray pointer in through an internal `sync` instance. Lives entirely in the write clock domain.

Parameters:
- ADDR_W, 4, memory address width; DEPTH = 2**ADDR_W entries
- DATA_W, 8, data word width
- NREQ, 2, number of write requesters (2..8)

Ports:
- clock  input  1  write-domain clock
- reset  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester write request, level, held until granted
- wdata  input  NREQ*DATA_W  requester data; requester i occupies bits [i*DATA_W +: DATA_W]
- grant  output  NREQ  one-hot, combinational; word accepted this cycle
- rptr_gray_async  input  ADDR_W+1  read-domain gray pointer, unsynchronized
- mem_we  output  1  registered memory write enable
- mem_waddr  output  ADDR_W  registered memory write address
- mem_wdata  output  DATA_W  registered memory write data
- wptr_gray  output  ADDR_W+1  registered gray write pointer, exported to the read domain
- full  output  1  registered full flag
- free_cnt  output  ADDR_W+1  registered conservative free-entry count, 0..DEPTH

Behaviour:
- Reset (async, active-high) clears everything:
  - grant=0, mem_we=0, mem_waddr=0, mem_wdata=0, wptr_gray=0, full=0, free_cnt=DEPTH.
  - Internal wbin=0, rr_last=NREQ-1, and both sync stages=0.
  - Reset asserted mid-operation discards any in-flight write: mem_we drops immediately.
- Synchronization:
  - rptr_gray_async passes through a `sync #(SIZE=ADDR_W+1)` instance (2 flops) to give rq2.
  - rq2 is converted gray-to-binary to give rbin_s.
- Arbitration:
  - grant[i]=1 only if full==0, req[i]==1, and i is the first requester with req set, searching circularly from rr_last+1.
  - At most one grant bit per cycle.
  - accept = |grant.
  - On accept, rr_last <= index of the granted requester at the clock edge.
  - A requester held high alone is granted every cycle until full.
- Write pipeline (latency 1):
  - On the edge ending an accept cycle N: mem_we<=1, mem_waddr<=wbin[ADDR_W-1:0], mem_wdata<=selected wdata, wbin<=wbin+1.
  - Otherwise mem_we<=0; address and data hold.
- Pointer publication:
  - wptr_gray <= bin2gray(wbin), one cycle after wbin updates, i.e. on edge N+2.
  - This guarantees the memory was written before the read side can observe the entry.
- Full:
  - wnext = wbin + accept (ADDR_W+1 bits, natural wrap).
  - full <= (bin2gray(wnext) == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]}).
  - Full asserts on the same edge that the DEPTH-th outstanding word is accepted.
  - Full deasserts no earlier than 2 cycles after the read side frees an entry (sync latency); this is conservative.
- free_cnt:
  - free_cnt <= DEPTH - (wnext - rbin_s), modulo 2**(ADDR_W+1).
  - free_cnt equals 0 exactly when full is asserted.
- Wrap-around:
  - wbin wraps from 2**(ADDR_W+1)-1 to 0; mem_waddr wraps from DEPTH-1 to 0.
  - No special cases at the wrap.
- Boundary conditions:
  - A request arriving while full is not granted and gets no grant pulse; its req stays high.
  - A request and a read-side pointer advance in the same cycle: full uses the old rq2; the new value takes effect 2 cycles later.
  - X on rptr_gray_async during reset has no effect on outputs.

Decomposition:
- Package `fifo_pkg`:
  - bin2gray and gray2bin functions, parameterized by width.
  - Default ADDR_W and DATA_W constants.
  - Typedef `ptr_t` for the ADDR_W+1 pointer.
- Sub-modules:
  - Reuse the existing `sync` for the read-pointer crossing.
  - One natural new sub-module: `rr_arbiter` (NREQ-wide, req/grant/rr_last, combinational grant plus registered last-grant).

Test Plan:
- Reset with req=2'b11 held: grant=0, free_cnt=16, full=0. After release, cycle 1 grant=2'b01, cycle 2 grant=2'b10, alternating.
- Only req[1] high with rptr_gray_async=0: 16 grants on consecutive cycles, with mem_waddr 0..15 each one cycle after its grant.
  - full=1 and free_cnt=0 on the edge after the 16th grant; the 17th cycle has no grant.
  - wptr_gray=5'b11000 (binary 16) one cycle after the last mem_we.
- While full, drive rptr_gray_async from 0 to 1 (1 read): full drops and free_cnt=1 three edges later; the next grant writes mem_waddr=0.
- Wrap: perform 40 writes with the reader tracking at a lag of 3.
  - mem_waddr sequence wraps 15→0 twice.
  - wptr_gray is always a single-bit change per increment.
  - full never asserts.
- Assert reset when the write pipeline has mem_we=1 and wbin=7: mem_we=0, wptr_gray=0, free_cnt=16 immediately (asynchronously). After release, the first write goes to mem_waddr=0.
- Three requesters (NREQ=3), all requesting: grant order is 0,1,2,0. When req[1] is dropped, the order becomes 0,2,0,2.
